// File: rtl/ddr3_dm_lane_tx_seq_if.sv
// Signal bundle between fabric/IOD side and the DDR3 DM lane transmit sequencer.
// master = fabric + IOD model driving requests, slave = the sequencer itself.
interface ddr3_dm_lane_tx_seq_if;
    logic       WR_VALID;
    logic       WR_READY;
    logic [7:0] WR_MASK;
    logic [7:0] TX_DATA_0;
    logic [3:0] OE_DATA_0;
    logic       DLY_REQ;
    logic       DLY_DIR;
    logic [6:0] DLY_STEPS;
    logic       DLY_LOAD_REQ;
    logic       DELAY_LINE_MOVE_0;
    logic       DELAY_LINE_DIRECTION_0;
    logic       DELAY_LINE_LOAD_0;
    logic       DELAY_LINE_OUT_OF_RANGE_0;
    logic       DLY_BUSY;
    logic       DLY_ERR;
    logic [6:0] DLY_TAP;

    modport master (
        output WR_VALID, WR_MASK, DLY_REQ, DLY_DIR, DLY_STEPS, DLY_LOAD_REQ,
               DELAY_LINE_OUT_OF_RANGE_0,
        input  WR_READY, TX_DATA_0, OE_DATA_0, DELAY_LINE_MOVE_0,
               DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0, DLY_BUSY, DLY_ERR, DLY_TAP
    );

    modport slave (
        input  WR_VALID, WR_MASK, DLY_REQ, DLY_DIR, DLY_STEPS, DLY_LOAD_REQ,
               DELAY_LINE_OUT_OF_RANGE_0,
        output WR_READY, TX_DATA_0, OE_DATA_0, DELAY_LINE_MOVE_0,
               DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0, DLY_BUSY, DLY_ERR, DLY_TAP
    );
endinterface

// File: rtl/ddr3_dm_lane_tx_seq.sv
// DDR3 DM lane transmit sequencer: BL8 mask bursts with OE framing plus a paced delay-line stepper.
// Build option DDR3_DM_IDLE_DRIVE_EN keeps OE asserted (pad parked low) in IDLE and reset.
//
// state    | meaning
// W_IDLE   | no burst, OE at idle level
// W_PRE    | OE preamble, data 0x00
// W_BURST  | latched mask on TX_DATA_0
// W_POST   | OE postamble, data 0x00, new burst may join seamlessly
// D_IDLE   | delay line quiet, accepts load / step requests
// D_LOAD   | one-cycle LOAD pulse, shadow tap reset
// D_SETUP  | direction settles before the first MOVE
// D_MOVE   | one-cycle MOVE pulse
// D_GAP    | spacing between MOVEs, range flag watched
module ddr3_dm_lane_tx_seq #(
    parameter int OE_PRE   = 1,
    parameter int OE_POST  = 1,
    parameter int DLY_INIT = 1,
    parameter int DLY_MAX  = 127,
    parameter int DLY_GAP  = 3
) (
    input  logic FAB_CLK,
    input  logic ARST_N,
    ddr3_dm_lane_tx_seq_if.slave bus
);

`ifdef DDR3_DM_IDLE_DRIVE_EN
    localparam logic [3:0] IDLE_OE = 4'hF;
`else
    localparam logic [3:0] IDLE_OE = 4'h0;
`endif

    localparam logic [1:0] PRE_LD  = (OE_PRE  > 0) ? 2'(OE_PRE  - 1) : 2'd0;
    localparam logic [1:0] POST_LD = (OE_POST > 0) ? 2'(OE_POST - 1) : 2'd0;
    localparam int GW = (DLY_GAP > 1) ? $clog2(DLY_GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_LD = GW'(DLY_GAP - 1);

    typedef enum logic [1:0] {W_IDLE, W_PRE, W_BURST, W_POST} wr_state_t;
    typedef enum logic [2:0] {D_IDLE, D_LOAD, D_SETUP, D_MOVE, D_GAP} dly_state_t;

    wr_state_t  wr_state;
    logic [7:0] mask_q;
    logic [7:0] tx_q;
    logic [3:0] oe_q;
    logic [1:0] frame_cnt;
    logic       accept;

    dly_state_t d_state;
    logic [6:0] steps_q;
    logic [6:0] tap_q;
    logic [GW-1:0] gap_cnt;
    logic       dir_q;
    logic       move_q;
    logic       load_q;
    logic       busy_q;
    logic       err_q;
    logic       step_ok;

    assign bus.WR_READY = (wr_state != W_PRE);
    assign accept       = bus.WR_VALID & bus.WR_READY;

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            wr_state  <= W_IDLE;
            mask_q    <= 8'h00;
            tx_q      <= 8'h00;
            oe_q      <= IDLE_OE;
            frame_cnt <= 2'd0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (accept) begin
                        mask_q <= bus.WR_MASK;
                        oe_q   <= 4'hF;
                        if (OE_PRE > 0) begin
                            wr_state  <= W_PRE;
                            frame_cnt <= PRE_LD;
                            tx_q      <= 8'h00;
                        end else begin
                            wr_state <= W_BURST;
                            tx_q     <= bus.WR_MASK;
                        end
                    end
                end
                W_PRE: begin
                    if (frame_cnt == 2'd0) begin
                        wr_state <= W_BURST;
                        tx_q     <= mask_q;
                    end else begin
                        frame_cnt <= frame_cnt - 2'd1;
                    end
                end
                W_BURST: begin
                    if (accept) begin
                        mask_q <= bus.WR_MASK;
                        tx_q   <= bus.WR_MASK;
                    end else if (OE_POST > 0) begin
                        wr_state  <= W_POST;
                        frame_cnt <= POST_LD;
                        tx_q      <= 8'h00;
                    end else begin
                        wr_state <= W_IDLE;
                        tx_q     <= 8'h00;
                        oe_q     <= IDLE_OE;
                    end
                end
                W_POST: begin
                    // A request arriving in the postamble rides the still-open OE window.
                    if (accept) begin
                        wr_state <= W_BURST;
                        mask_q   <= bus.WR_MASK;
                        tx_q     <= bus.WR_MASK;
                    end else if (frame_cnt == 2'd0) begin
                        wr_state <= W_IDLE;
                        oe_q     <= IDLE_OE;
                    end else begin
                        frame_cnt <= frame_cnt - 2'd1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    assign bus.TX_DATA_0 = tx_q;
    assign bus.OE_DATA_0 = oe_q;

    // Refuse a step that would push the shadow tap past either end.
    assign step_ok = dir_q ? (tap_q < 7'(DLY_MAX)) : (tap_q != 7'd0);

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            d_state <= D_IDLE;
            steps_q <= 7'd0;
            tap_q   <= 7'(DLY_INIT);
            gap_cnt <= '0;
            dir_q   <= 1'b0;
            move_q  <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (d_state)
                D_IDLE: begin
                    if (bus.DLY_LOAD_REQ) begin
                        d_state <= D_LOAD;
                        load_q  <= 1'b1;
                        tap_q   <= 7'(DLY_INIT);
                        err_q   <= 1'b0;
                    end else if (bus.DLY_REQ) begin
                        d_state <= D_SETUP;
                        dir_q   <= bus.DLY_DIR;
                        steps_q <= bus.DLY_STEPS;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                D_LOAD: begin
                    load_q  <= 1'b0;
                    d_state <= D_IDLE;
                end
                D_SETUP, D_GAP: begin
                    if (d_state == D_GAP && bus.DELAY_LINE_OUT_OF_RANGE_0) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        d_state <= D_IDLE;
                    end else if (d_state == D_GAP && gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (steps_q == 7'd0) begin
                        busy_q  <= 1'b0;
                        d_state <= D_IDLE;
                    end else if (!step_ok) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        d_state <= D_IDLE;
                    end else begin
                        move_q  <= 1'b1;
                        tap_q   <= dir_q ? tap_q + 7'd1 : tap_q - 7'd1;
                        steps_q <= steps_q - 7'd1;
                        d_state <= D_MOVE;
                    end
                end
                D_MOVE: begin
                    move_q  <= 1'b0;
                    gap_cnt <= GAP_LD;
                    d_state <= D_GAP;
                end
                default: d_state <= D_IDLE;
            endcase
        end
    end

    assign bus.DELAY_LINE_MOVE_0      = move_q;
    assign bus.DELAY_LINE_DIRECTION_0 = dir_q;
    assign bus.DELAY_LINE_LOAD_0      = load_q;
    assign bus.DLY_BUSY               = busy_q;
    assign bus.DLY_ERR                = err_q;
    assign bus.DLY_TAP                = tap_q;

endmodule

// File: tb/tb_ddr3_dm_lane_tx_seq.sv
// Directed bench for ddr3_dm_lane_tx_seq with default parameters (PRE=1, POST=1, INIT=1, GAP=3).
module tb_ddr3_dm_lane_tx_seq;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   moves;

`ifdef DDR3_DM_IDLE_DRIVE_EN
    localparam logic [3:0] EXP_IDLE_OE = 4'hF;
`else
    localparam logic [3:0] EXP_IDLE_OE = 4'h0;
`endif

    ddr3_dm_lane_tx_seq_if bus();

    ddr3_dm_lane_tx_seq #(
        .OE_PRE(1), .OE_POST(1), .DLY_INIT(1), .DLY_MAX(127), .DLY_GAP(3)
    ) dut (
        .FAB_CLK(clk),
        .ARST_N (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx"},   32'(bus.TX_DATA_0), 32'h00);
        chk({tag, "_oe"},   32'(bus.OE_DATA_0), 32'(EXP_IDLE_OE));
        chk({tag, "_rdy"},  32'(bus.WR_READY), 32'd1);
        chk({tag, "_move"}, 32'(bus.DELAY_LINE_MOVE_0), 32'd0);
        chk({tag, "_dir"},  32'(bus.DELAY_LINE_DIRECTION_0), 32'd0);
        chk({tag, "_load"}, 32'(bus.DELAY_LINE_LOAD_0), 32'd0);
        chk({tag, "_busy"}, 32'(bus.DLY_BUSY), 32'd0);
        chk({tag, "_err"},  32'(bus.DLY_ERR), 32'd0);
        chk({tag, "_tap"},  32'(bus.DLY_TAP), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0;
        bus.WR_VALID = 1'b0; bus.WR_MASK = 8'h00;
        bus.DLY_REQ = 1'b0; bus.DLY_DIR = 1'b0; bus.DLY_STEPS = 7'd0;
        bus.DLY_LOAD_REQ = 1'b0; bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
        repeat (3) tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        chk_reset_vals("post_rst");

        // single burst 0xA5
        bus.WR_VALID = 1'b1; bus.WR_MASK = 8'hA5;
        tick(); bus.WR_VALID = 1'b0;
        chk("b1_pre_tx", 32'(bus.TX_DATA_0), 32'h00);
        chk("b1_pre_oe", 32'(bus.OE_DATA_0), 32'hF);
        chk("b1_pre_rdy", 32'(bus.WR_READY), 32'd0);
        tick();
        chk("b1_data_tx", 32'(bus.TX_DATA_0), 32'hA5);
        chk("b1_data_oe", 32'(bus.OE_DATA_0), 32'hF);
        chk("b1_data_rdy", 32'(bus.WR_READY), 32'd1);
        tick();
        chk("b1_post_tx", 32'(bus.TX_DATA_0), 32'h00);
        chk("b1_post_oe", 32'(bus.OE_DATA_0), 32'hF);
        tick();
        chk("b1_idle_oe", 32'(bus.OE_DATA_0), 32'(EXP_IDLE_OE));

        // accept during postamble joins without a new preamble
        bus.WR_VALID = 1'b1; bus.WR_MASK = 8'hC3;
        tick(); bus.WR_VALID = 1'b0;
        tick();
        chk("pj_first_tx", 32'(bus.TX_DATA_0), 32'hC3);
        tick();
        chk("pj_post_oe", 32'(bus.OE_DATA_0), 32'hF);
        bus.WR_VALID = 1'b1; bus.WR_MASK = 8'h3C;
        tick(); bus.WR_VALID = 1'b0;
        chk("pj_second_tx", 32'(bus.TX_DATA_0), 32'h3C);
        chk("pj_second_oe", 32'(bus.OE_DATA_0), 32'hF);
        tick();
        chk("pj_post2_tx", 32'(bus.TX_DATA_0), 32'h00);
        chk("pj_post2_oe", 32'(bus.OE_DATA_0), 32'hF);
        tick();
        chk("pj_idle_oe", 32'(bus.OE_DATA_0), 32'(EXP_IDLE_OE));

        // back-to-back 0x01, 0x80, 0xFF with WR_VALID held
        bus.WR_VALID = 1'b1; bus.WR_MASK = 8'h01;
        tick();
        chk("bb_pre_oe", 32'(bus.OE_DATA_0), 32'hF);
        chk("bb_pre_tx", 32'(bus.TX_DATA_0), 32'h00);
        bus.WR_MASK = 8'h80;
        tick();
        chk("bb_d0_tx", 32'(bus.TX_DATA_0), 32'h01);
        tick();
        chk("bb_d1_tx", 32'(bus.TX_DATA_0), 32'h80);
        chk("bb_d1_oe", 32'(bus.OE_DATA_0), 32'hF);
        bus.WR_MASK = 8'hFF;
        tick();
        chk("bb_d2_tx", 32'(bus.TX_DATA_0), 32'hFF);
        chk("bb_d2_oe", 32'(bus.OE_DATA_0), 32'hF);
        bus.WR_VALID = 1'b0;
        tick();
        chk("bb_post_tx", 32'(bus.TX_DATA_0), 32'h00);
        chk("bb_post_oe", 32'(bus.OE_DATA_0), 32'hF);
        tick();
        chk("bb_idle_oe", 32'(bus.OE_DATA_0), 32'(EXP_IDLE_OE));

        // increment 3 steps: MOVE at cycles 2, 6, 10 after accept
        bus.DLY_REQ = 1'b1; bus.DLY_DIR = 1'b1; bus.DLY_STEPS = 7'd3;
        tick(); bus.DLY_REQ = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            chk($sformatf("inc_move_c%0d", i), 32'(bus.DELAY_LINE_MOVE_0),
                32'((i == 2) || (i == 6) || (i == 10)));
            chk($sformatf("inc_dir_c%0d", i), 32'(bus.DELAY_LINE_DIRECTION_0), 32'd1);
            chk($sformatf("inc_busy_c%0d", i), 32'(bus.DLY_BUSY), 32'(i <= 13));
            if (i == 2) chk("inc_tap_first", 32'(bus.DLY_TAP), 32'd2);
            if (i == 14) chk("inc_tap_end", 32'(bus.DLY_TAP), 32'd4);
            tick();
        end

        // zero steps: busy for one cycle, no MOVE
        bus.DLY_REQ = 1'b1; bus.DLY_STEPS = 7'd0;
        tick(); bus.DLY_REQ = 1'b0;
        chk("z_busy", 32'(bus.DLY_BUSY), 32'd1);
        chk("z_move", 32'(bus.DELAY_LINE_MOVE_0), 32'd0);
        tick();
        chk("z_busy_end", 32'(bus.DLY_BUSY), 32'd0);
        chk("z_move_end", 32'(bus.DELAY_LINE_MOVE_0), 32'd0);
        chk("z_tap", 32'(bus.DLY_TAP), 32'd4);

        // load back to 1
        bus.DLY_LOAD_REQ = 1'b1;
        tick(); bus.DLY_LOAD_REQ = 1'b0;
        chk("ld1_load", 32'(bus.DELAY_LINE_LOAD_0), 32'd1);
        chk("ld1_tap", 32'(bus.DLY_TAP), 32'd1);
        tick();
        chk("ld1_load_end", 32'(bus.DELAY_LINE_LOAD_0), 32'd0);

        // decrement 5 from tap 1: one MOVE then range error
        bus.DLY_REQ = 1'b1; bus.DLY_DIR = 1'b0; bus.DLY_STEPS = 7'd5;
        tick(); bus.DLY_REQ = 1'b0;
        moves = 0;
        for (int i = 1; i <= 10; i++) begin
            moves += int'(bus.DELAY_LINE_MOVE_0);
            tick();
        end
        chk("dec_moves", 32'(moves), 32'd1);
        chk("dec_err", 32'(bus.DLY_ERR), 32'd1);
        chk("dec_tap", 32'(bus.DLY_TAP), 32'd0);
        chk("dec_busy", 32'(bus.DLY_BUSY), 32'd0);

        // load wins over a simultaneous step request
        bus.DLY_LOAD_REQ = 1'b1; bus.DLY_REQ = 1'b1; bus.DLY_DIR = 1'b1; bus.DLY_STEPS = 7'd2;
        tick(); bus.DLY_LOAD_REQ = 1'b0; bus.DLY_REQ = 1'b0;
        chk("ld2_load", 32'(bus.DELAY_LINE_LOAD_0), 32'd1);
        chk("ld2_tap", 32'(bus.DLY_TAP), 32'd1);
        chk("ld2_err", 32'(bus.DLY_ERR), 32'd0);
        chk("ld2_busy", 32'(bus.DLY_BUSY), 32'd0);
        tick();
        chk("ld2_load_end", 32'(bus.DELAY_LINE_LOAD_0), 32'd0);
        chk("ld2_busy_end", 32'(bus.DLY_BUSY), 32'd0);

        // out-of-range flag after the second of 4 MOVEs
        bus.DLY_REQ = 1'b1; bus.DLY_DIR = 1'b1; bus.DLY_STEPS = 7'd4;
        tick(); bus.DLY_REQ = 1'b0;
        moves = 0;
        for (int i = 1; i <= 16; i++) begin
            moves += int'(bus.DELAY_LINE_MOVE_0);
            if (i == 7) bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b1;
            if (i == 8) chk("oor_busy_drop", 32'(bus.DLY_BUSY), 32'd0);
            tick();
        end
        bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
        chk("oor_moves", 32'(moves), 32'd2);
        chk("oor_err", 32'(bus.DLY_ERR), 32'd1);
        chk("oor_tap", 32'(bus.DLY_TAP), 32'd3);

        // reset in the middle of a burst and a step sequence
        bus.WR_VALID = 1'b1; bus.WR_MASK = 8'h5A;
        bus.DLY_REQ = 1'b1; bus.DLY_DIR = 1'b1; bus.DLY_STEPS = 7'd2;
        tick(); bus.WR_VALID = 1'b0; bus.DLY_REQ = 1'b0;
        tick();
        chk("mid_tx", 32'(bus.TX_DATA_0), 32'h5A);
        chk("mid_move", 32'(bus.DELAY_LINE_MOVE_0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk_reset_vals("after_mid_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
